// File: rtl/nfca_pkg.sv
// Shared ISO14443A types: symbol codes, serializer/deserializer states, odd parity.
package nfca_pkg;

  typedef enum logic [1:0] {SYM_S, SYM_0, SYM_1, SYM_E} sym_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SOF, ST_DATA, ST_PAR, ST_NEXT, ST_EOF, ST_DONE
  } state_t;

  localparam int MAX_FRAME_BYTES_DEF = 64;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // A bit count of 0 or above 8 means a whole byte.
  function automatic logic [3:0] eff_bits(input logic [3:0] datab);
    return ((datab == 4'd0) || (datab > 4'd8)) ? 4'd8 : datab;
  endfunction

endpackage

// File: rtl/nfca_tx_tobits_if.sv
// Byte-stream input and symbol-stream output of the TX serializer.
interface nfca_tx_tobits_if;
  import nfca_pkg::*;

  logic       tx_tvalid;
  logic       tx_tready;
  logic [7:0] tx_tdata;
  logic [3:0] tx_tdatab;
  logic       tx_tlast;
  logic       tx_sym_valid;
  logic       tx_sym_ready;
  sym_t       tx_sym;

  modport slave (
    input  tx_tvalid, tx_tdata, tx_tdatab, tx_tlast, tx_sym_ready,
    output tx_tready, tx_sym_valid, tx_sym
  );

  modport master (
    output tx_tvalid, tx_tdata, tx_tdatab, tx_tlast, tx_sym_ready,
    input  tx_tready, tx_sym_valid, tx_sym
  );
endinterface

// File: rtl/nfca_tx_tobits.sv
// PCD frame serializer: bytes in, S / LSB-first data / odd parity / E symbols out.
// One-entry hold buffer in front of the shifter; registered symbol output, one symbol per >=2 cycles.
module nfca_tx_tobits
  import nfca_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tx_abort_i,
  nfca_tx_tobits_if.slave   tx_if,
  output logic              tx_busy_o,
  output logic              tx_done_o,
  output logic              tx_err_o,
  output logic [2:0]        tx_remainb_o
);

  localparam int CW = $clog2(MAX_FRAME_BYTES + 2);

  state_t          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [3:0]      hold_bits_q, hold_bits_d;
  logic            hold_last_q, hold_last_d;
  logic            hold_v_q, hold_v_d;
  logic            last_taken_q, last_taken_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic [3:0]      nbits_q, nbits_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            cur_last_q, cur_last_d;
  logic            err_q, err_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic            sym_vld_q, sym_vld_d;
  sym_t            sym_q, sym_d;
  logic            done_q, done_d;
  logic            err_out_q, err_out_d;
  logic [2:0]      remainb_q, remainb_d;

  logic            beat_acc;
  logic            sym_hs;
  logic [3:0]      beat_bits;
  logic [3:0]      rem_full;

  assign tx_if.tx_tready = ~hold_v_q & ~last_taken_q &
                           (state_q inside {ST_IDLE, ST_SOF, ST_DATA, ST_PAR});
  assign beat_acc  = tx_if.tx_tvalid & tx_if.tx_tready;
  assign sym_hs    = sym_vld_q & tx_if.tx_sym_ready;
  assign beat_bits = tx_if.tx_tlast ? eff_bits(tx_if.tx_tdatab) : 4'd8;
  assign rem_full  = 4'd8 - beat_bits;

  assign tx_if.tx_sym_valid = sym_vld_q;
  assign tx_if.tx_sym       = sym_q;
  assign tx_busy_o          = (state_q != ST_IDLE);
  assign tx_done_o          = done_q;
  assign tx_err_o           = err_out_q;
  assign tx_remainb_o       = remainb_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_bits_d  = hold_bits_q;
    hold_last_d  = hold_last_q;
    hold_v_d     = hold_v_q;
    last_taken_d = last_taken_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    nbits_d      = nbits_q;
    cnt_d        = cnt_q;
    cur_last_d   = cur_last_q;
    err_d        = err_q;
    byte_cnt_d   = byte_cnt_q;
    sym_vld_d    = sym_vld_q;
    sym_d        = sym_q;
    done_d       = 1'b0;
    err_out_d    = 1'b0;
    remainb_d    = remainb_q;

    // Beats are only accepted while the hold buffer is empty, so this never
    // collides with the hold-to-shifter moves in SOF and NEXT below.
    if (beat_acc) begin
      if (state_q != ST_IDLE && byte_cnt_q == CW'(MAX_FRAME_BYTES)) begin
        err_d        = 1'b1;
        last_taken_d = 1'b1;
      end else begin
        hold_d       = tx_if.tx_tdata;
        hold_bits_d  = beat_bits;
        hold_last_d  = tx_if.tx_tlast;
        hold_v_d     = 1'b1;
        byte_cnt_d   = (state_q == ST_IDLE) ? CW'(1) : byte_cnt_q + CW'(1);
        if (tx_if.tx_tlast) begin
          last_taken_d = 1'b1;
          remainb_d    = rem_full[2:0];
        end
        if (state_q == ST_IDLE) begin
          err_d   = 1'b0;
          state_d = ST_SOF;
        end
      end
    end

    case (state_q)
      ST_SOF: begin
        if (!sym_vld_q) begin
          sym_vld_d = 1'b1;
          sym_d     = SYM_S;
        end else if (sym_hs) begin
          sym_vld_d  = 1'b0;
          shift_d    = hold_q;
          byte_d     = hold_q;
          nbits_d    = hold_bits_q;
          cur_last_d = hold_last_q;
          hold_v_d   = 1'b0;
          cnt_d      = 4'd0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!sym_vld_q) begin
          sym_vld_d = 1'b1;
          sym_d     = shift_q[0] ? SYM_1 : SYM_0;
        end else if (sym_hs) begin
          sym_vld_d = 1'b0;
          shift_d   = {1'b0, shift_q[7:1]};
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == nbits_q)
            state_d = (nbits_q == 4'd8) ? ST_PAR : ST_NEXT;
        end
      end
      ST_PAR: begin
        if (!sym_vld_q) begin
          sym_vld_d = 1'b1;
          sym_d     = odd_par(byte_q) ? SYM_1 : SYM_0;
        end else if (sym_hs) begin
          sym_vld_d = 1'b0;
          state_d   = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (cur_last_q) begin
          state_d = ST_EOF;
        end else if (hold_v_q) begin
          shift_d    = hold_q;
          byte_d     = hold_q;
          nbits_d    = hold_bits_q;
          cur_last_d = hold_last_q;
          hold_v_d   = 1'b0;
          cnt_d      = 4'd0;
          state_d    = ST_DATA;
        end else begin
          err_d   = 1'b1;
          state_d = ST_EOF;
        end
      end
      ST_EOF: begin
        if (!sym_vld_q) begin
          sym_vld_d = 1'b1;
          sym_d     = SYM_E;
        end else if (sym_hs) begin
          sym_vld_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d       = 1'b1;
        err_out_d    = err_q;
        err_d        = 1'b0;
        last_taken_d = 1'b0;
        byte_cnt_d   = '0;
        state_d      = ST_IDLE;
      end
      default: ;
    endcase

    if (tx_abort_i) begin
      state_d      = ST_IDLE;
      hold_v_d     = 1'b0;
      last_taken_d = 1'b0;
      sym_vld_d    = 1'b0;
      err_d        = 1'b0;
      byte_cnt_d   = '0;
      done_d       = (state_q != ST_IDLE);
      err_out_d    = (state_q != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      hold_bits_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_v_q     <= 1'b0;
      last_taken_q <= 1'b0;
      shift_q      <= '0;
      byte_q       <= '0;
      nbits_q      <= '0;
      cnt_q        <= '0;
      cur_last_q   <= 1'b0;
      err_q        <= 1'b0;
      byte_cnt_q   <= '0;
      sym_vld_q    <= 1'b0;
      sym_q        <= SYM_E;
      done_q       <= 1'b0;
      err_out_q    <= 1'b0;
      remainb_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_bits_q  <= hold_bits_d;
      hold_last_q  <= hold_last_d;
      hold_v_q     <= hold_v_d;
      last_taken_q <= last_taken_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      nbits_q      <= nbits_d;
      cnt_q        <= cnt_d;
      cur_last_q   <= cur_last_d;
      err_q        <= err_d;
      byte_cnt_q   <= byte_cnt_d;
      sym_vld_q    <= sym_vld_d;
      sym_q        <= sym_d;
      done_q       <= done_d;
      err_out_q    <= err_out_d;
      remainb_q    <= remainb_d;
    end
  end

endmodule

// File: tb/tb_nfca_tx_tobits.sv
// Directed bench for nfca_tx_tobits; symbol streams compared against hand-derived strings.
module tb_nfca_tx_tobits;
  import nfca_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_abort = 1'b0;
  logic       tx_busy, tx_done, tx_err;
  logic [2:0] tx_remainb;

  int    errors = 0;
  int    checks = 0;
  string got = "";
  int    done_cnt = 0;
  logic  done_err = 1'b0;

  nfca_tx_tobits_if bus();

  nfca_tx_tobits #(.MAX_FRAME_BYTES(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .tx_abort_i   (tx_abort),
    .tx_if        (bus),
    .tx_busy_o    (tx_busy),
    .tx_done_o    (tx_done),
    .tx_err_o     (tx_err),
    .tx_remainb_o (tx_remainb)
  );

  always #5 clk = ~clk;

  function automatic string sym2str(input sym_t s);
    case (s)
      SYM_S:   return "S";
      SYM_0:   return "0";
      SYM_1:   return "1";
      default: return "E";
    endcase
  endfunction

  // Record every symbol handshake and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn && bus.tx_sym_valid && bus.tx_sym_ready) got = {got, sym2str(bus.tx_sym)};
    if (rstn && tx_done) begin
      done_cnt = done_cnt + 1;
      done_err = tx_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [3:0] b, input logic l);
    int n = 0;
    bus.tx_tvalid = 1'b1;
    bus.tx_tdata  = d;
    bus.tx_tdatab = b;
    bus.tx_tlast  = l;
    while (!bus.tx_tready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat_accept_timeout", 32'(n < 2000), 32'd1);
    @(posedge clk); #1;
    bus.tx_tvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start);
    int n = 0;
    while (done_cnt == start && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_timeout"}, 32'(done_cnt == start + 1), 32'd1);
  endtask

  task automatic wait_len(input int len);
    int n = 0;
    while (got.len() < len && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sym_count_timeout", 32'(got.len() >= len), 32'd1);
  endtask

  // Each 9-symbol group after S must carry an odd number of ones.
  task automatic chk_par(input string tag, input string s, input int groups);
    for (int g = 0; g < groups; g++) begin
      int ones = 0;
      for (int k = 0; k < 9; k++)
        if (s.len() > 1 + 9*g + k && s[1 + 9*g + k] == 8'h31) ones++;
      chk($sformatf("%s_par%0d", tag, g), 32'(ones % 2), 32'd1);
    end
  endtask

  initial begin
    int   start;
    sym_t snap_sym;
    bus.tx_tvalid    = 1'b0;
    bus.tx_tdata     = 8'h00;
    bus.tx_tdatab    = 4'd0;
    bus.tx_tlast     = 1'b0;
    bus.tx_sym_ready = 1'b1;

    // Reset values, sampled while reset is held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready",    32'(bus.tx_tready),    32'd1);
    chk("rst_sym_valid", 32'(bus.tx_sym_valid), 32'd0);
    chk("rst_sym",       32'(bus.tx_sym),       32'(SYM_E));
    chk("rst_busy",      32'(tx_busy),          32'd0);
    chk("rst_done",      32'(tx_done),          32'd0);
    chk("rst_err",       32'(tx_err),           32'd0);
    chk("rst_remainb",   32'(tx_remainb),       32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: REQA, 7-bit short frame, no parity.
    got = ""; start = done_cnt;
    send_beat(8'h26, 4'd7, 1'b1);
    wait_done("reqa", start);
    chk_str("reqa_syms", got, "S0110010E");
    chk("reqa_err",     32'(done_err),   32'd0);
    chk("reqa_remainb", 32'(tx_remainb), 32'd1);

    // 2: two full bytes, tlast on the second.
    got = ""; start = done_cnt;
    send_beat(8'h93, 4'd0, 1'b0);
    send_beat(8'h20, 4'd0, 1'b1);
    wait_done("sel", start);
    chk_str("sel_syms", got, "S110010011000001000E");
    chk("sel_err",     32'(done_err),   32'd0);
    chk("sel_remainb", 32'(tx_remainb), 32'd0);
    chk_par("sel", got, 2);

    // 3: anticollision, partial 4-bit last byte.
    got = ""; start = done_cnt;
    send_beat(8'h93, 4'd0, 1'b0);
    send_beat(8'h05, 4'd4, 1'b1);
    wait_done("ac", start);
    chk_str("ac_syms", got, "S1100100111010E");
    chk("ac_err",     32'(done_err),   32'd0);
    chk("ac_remainb", 32'(tx_remainb), 32'd4);
    chk_par("ac", got, 1);

    // 4: underflow, no tlast and no further beat.
    got = ""; start = done_cnt;
    send_beat(8'hA5, 4'd0, 1'b0);
    wait_done("uf", start);
    chk_str("uf_syms", got, "S101001011E");
    chk("uf_err", 32'(done_err), 32'd1);
    chk_par("uf", got, 1);

    // 5: backpressure mid-DATA for 10 cycles.
    got = ""; start = done_cnt;
    send_beat(8'hA5, 4'd8, 1'b1);
    wait_len(3);
    bus.tx_sym_ready = 1'b0;
    @(posedge clk); #1;
    snap_sym = bus.tx_sym;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid%0d", i), 32'(bus.tx_sym_valid), 32'd1);
      chk($sformatf("bp_sym%0d", i),   32'(bus.tx_sym),       32'(snap_sym));
    end
    bus.tx_sym_ready = 1'b1;
    wait_done("bp", start);
    chk_str("bp_syms", got, "S101001011E");
    chk("bp_err",     32'(done_err),   32'd0);
    chk("bp_remainb", 32'(tx_remainb), 32'd0);

    // 6: abort at bit 3 of the first byte, then a clean REQA-like frame.
    got = "";
    send_beat(8'h93, 4'd0, 1'b1);
    wait_len(4);
    tx_abort = 1'b1;
    @(posedge clk); #1;
    tx_abort = 1'b0;
    chk("ab_sym_valid", 32'(bus.tx_sym_valid), 32'd0);
    chk("ab_done",      32'(tx_done),          32'd1);
    chk("ab_err",       32'(tx_err),           32'd1);
    chk("ab_tready",    32'(bus.tx_tready),    32'd1);
    chk("ab_busy",      32'(tx_busy),          32'd0);
    @(posedge clk); #1;
    chk("ab_done_pulse", 32'(tx_done), 32'd0);
    got = ""; start = done_cnt;
    send_beat(8'h52, 4'd7, 1'b1);
    wait_done("wupa", start);
    chk_str("wupa_syms", got, "S0100101E");
    chk("wupa_err",     32'(done_err),   32'd0);
    chk("wupa_remainb", 32'(tx_remainb), 32'd1);

    // 7: overlength with MAX_FRAME_BYTES=2; third byte dropped.
    got = ""; start = done_cnt;
    send_beat(8'h93, 4'd0, 1'b0);
    send_beat(8'h20, 4'd0, 1'b0);
    send_beat(8'hFF, 4'd0, 1'b0);
    wait_done("ovl", start);
    chk_str("ovl_syms", got, "S110010011000001000E");
    chk("ovl_err", 32'(done_err), 32'd1);
    chk_par("ovl", got, 2);
    @(posedge clk); #1;
    chk("ovl_idle_busy", 32'(tx_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
